// File: rtl/xillybus_rd_stream_arb.sv
// Read-stream concentrator: round-robin burst arbiter over NUM_CH valid/ready channels
// feeding a registered-read FIFO that drives the Xillybus user_r_* read port.
module xillybus_rd_stream_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int HEADER_EN  = 1
) (
    input  logic                     bus_clk_w,
    input  logic                     bus_rst_n_w,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_last,
    input  logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     user_r_rden,
    input  logic                     user_r_open,
    output logic [DATA_W-1:0]        user_r_data,
    output logic                     user_r_empty,
    output logic                     user_r_eof,
    output logic                     overflow_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;

    state_t              state, state_nxt;
    logic [CH_W-1:0]     grant, grant_nxt;
    logic [CH_W-1:0]     rr, rr_nxt;
    logic [CH_W-1:0]     idx;
    logic                found;
    logic                seq_inc;
    logic [15:0]         burst_seq [NUM_CH];
    logic [NUM_CH-1:0]   done_flag;
    logic [31:0]         hdr_word;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                full, push, pop;
    logic [DATA_W-1:0]   push_data;

    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign user_r_empty = (count == '0);
    assign pop          = user_r_rden & ~user_r_empty;
    assign user_r_eof   = (&done_flag) & user_r_empty & (state == IDLE);
    assign hdr_word     = {8'hA5, 4'(grant), 4'h0, burst_seq[grant]};

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr;
        push      = 1'b0;
        push_data = '0;
        seq_inc   = 1'b0;
        ch_ready  = '0;
        found     = 1'b0;
        idx       = '0;
        unique case (state)
            IDLE: begin
                // Search starts just after the last served channel, so it gets lowest priority.
                if (user_r_open) begin
                    for (int k = 1; k <= NUM_CH; k++) begin
                        idx = CH_W'((int'(rr) + k) % NUM_CH);
                        if (!found && ch_valid[idx]) begin
                            found     = 1'b1;
                            grant_nxt = idx;
                        end
                    end
                    if (found)
                        state_nxt = (HEADER_EN != 0) ? HDR : BURST;
                end
            end
            HDR: begin
                if (user_r_open && !full) begin
                    push      = 1'b1;
                    push_data = hdr_word[DATA_W-1:0];
                    state_nxt = BURST;
                end
            end
            BURST: begin
                ch_ready[grant] = user_r_open & ~full;
                if (ch_valid[grant] && ch_ready[grant]) begin
                    push      = 1'b1;
                    push_data = ch_data[int'(grant)*DATA_W +: DATA_W];
                    if (ch_last[grant]) begin
                        rr_nxt    = grant;
                        seq_inc   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk_w or negedge bus_rst_n_w) begin
        if (!bus_rst_n_w) begin
            state        <= IDLE;
            grant        <= '0;
            rr           <= '0;
            done_flag    <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
            user_r_data  <= '0;
            for (int i = 0; i < NUM_CH; i++)
                burst_seq[i] <= '0;
        end else begin
            if (user_r_rden && user_r_empty)
                overflow_err <= 1'b1;
            if (pop)
                user_r_data <= mem[rd_ptr];
            // A closed file discards everything buffered and restarts arbitration from scratch.
            if (!user_r_open) begin
                state     <= IDLE;
                grant     <= '0;
                rr        <= '0;
                done_flag <= '0;
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                for (int i = 0; i < NUM_CH; i++)
                    burst_seq[i] <= '0;
            end else begin
                state     <= state_nxt;
                grant     <= grant_nxt;
                rr        <= rr_nxt;
                done_flag <= done_flag | ch_done;
                if (seq_inc)
                    burst_seq[grant] <= burst_seq[grant] + 16'd1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge bus_clk_w) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_xillybus_rd_stream_arb.sv
// Bench for xillybus_rd_stream_arb: directed scenarios plus random rounds checked
// against a burst-level round-robin model of the output word stream.
module tb_xillybus_rd_stream_arb;

    localparam int NCH = 4;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_valid, ch_last, ch_done, ch_ready;
    logic              rden, open_i;
    logic [DW-1:0]     rdata;
    logic              empty, eof, ovf;

    xillybus_rd_stream_arb #(
        .NUM_CH(NCH), .DATA_W(DW), .FIFO_DEPTH(16), .HEADER_EN(1)
    ) dut (
        .bus_clk_w(clk), .bus_rst_n_w(rst_n),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_last(ch_last), .ch_done(ch_done),
        .ch_ready(ch_ready), .user_r_rden(rden), .user_r_open(open_i),
        .user_r_data(rdata), .user_r_empty(empty), .user_r_eof(eof), .overflow_err(ovf)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] bw [NCH][32];
    int          blen [NCH];
    int          bidx [NCH];
    bit          acc [NCH];
    bit          rd_pend;
    logic [31:0] expq [$];
    int          mrr;
    logic [15:0] mseq [NCH];
    int          gord [6];
    int          exp_ord [6] = '{1, 3, 0, 1, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_engine();
        for (int i = 0; i < NCH; i++) begin
            blen[i] = 0; bidx[i] = 0; acc[i] = 0; mseq[i] = '0;
        end
        rd_pend = 0; mrr = 0; expq.delete();
        ch_valid = '0; ch_last = '0; ch_data = '0; ch_done = '0; rden = 1'b0;
    endtask

    task automatic do_reset(input bit open_after);
        @(negedge clk);
        rst_n = 1'b0; open_i = 1'b0;
        clear_engine();
        repeat (2) @(negedge clk);
        rst_n = 1'b1; open_i = open_after;
        @(negedge clk);
    endtask

    // Reference: every masked channel offers one burst; bursts leave in rotation order
    // starting after the previously served channel, each behind its own header.
    task automatic load_round(input logic [NCH-1:0] mask, input int len, input bit rnd);
        int last_c;
        last_c = mrr;
        for (int i = 0; i < NCH; i++) begin
            bidx[i] = 0;
            blen[i] = mask[i] ? ((len > 0) ? len : int'($urandom_range(1, 6))) : 0;
            for (int k = 0; k < blen[i]; k++)
                bw[i][k] = rnd ? $urandom : (32'hD000_0000 | (i << 16) | k);
        end
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (mrr + k) % NCH;
            if (mask[c]) begin
                expq.push_back({8'hA5, 4'(c), 4'h0, mseq[c]});
                for (int j = 0; j < blen[c]; j++) expq.push_back(bw[c][j]);
                mseq[c] = mseq[c] + 16'd1;
                last_c = c;
            end
        end
        mrr = last_c;
    endtask

    // One clock: retire last edge's handshakes/reads, drive this cycle, wait to next negedge.
    // rd_mode 0: no read, 1: random read, 2: read whenever non-empty.
    task automatic step(input int rd_mode);
        for (int i = 0; i < NCH; i++) if (acc[i]) bidx[i]++;
        if (rd_pend) begin
            n_tests++;
            assert (expq.size() != 0) else begin
                n_fail++;
                $error("FAIL rd_extra: observed word %h expected none", rdata);
            end
            if (expq.size() != 0) chk("rd_word", rdata, expq.pop_front());
        end
        for (int i = 0; i < NCH; i++) begin
            if (bidx[i] < blen[i]) begin
                ch_valid[i] = 1'b1;
                ch_data[i*DW +: DW] = bw[i][bidx[i]];
                ch_last[i] = (bidx[i] == blen[i] - 1);
            end else begin
                ch_valid[i] = 1'b0;
                ch_last[i] = 1'b0;
            end
        end
        case (rd_mode)
            1:       rden = !empty && ($urandom_range(0, 3) != 0);
            2:       rden = !empty;
            default: rden = 1'b0;
        endcase
        rd_pend = rden;
        for (int i = 0; i < NCH; i++) acc[i] = ch_valid[i] && ch_ready[i];
        @(negedge clk);
    endtask

    function automatic bit consumed();
        for (int i = 0; i < NCH; i++) if (bidx[i] < blen[i]) return 0;
        return 1;
    endfunction

    task automatic drain();
        int t;
        t = 0;
        while (!(consumed() && expq.size() == 0 && !rd_pend) && t < 3000) begin
            step(1);
            t++;
        end
        n_tests++;
        assert (t < 3000) else begin
            n_fail++;
            $error("FAIL drain_timeout: observed %0d words left expected 0", expq.size());
        end
        chk("empty_after_drain", empty, 1'b1);
    endtask

    initial begin
        int t, ng;
        rst_n = 1'b0; open_i = 1'b0;
        clear_engine();

        // Reset values
        do_reset(0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_eof", eof, 1'b0);
        chk("rst_ready", ch_ready, 4'h0);
        chk("rst_data", rdata, 32'h0);
        chk("rst_ovf", ovf, 1'b0);

        // Single 3-word burst on ch2, then a second burst shows seq advanced
        do_reset(1);
        load_round(4'b0100, 3, 0);
        repeat (10) step(0);
        drain();
        load_round(4'b0100, 1, 0);
        drain();

        // Three channels continuously valid with 1-word bursts
        do_reset(1);
        ch_last = 4'hF;
        for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 32'hC000_0000 | i;
        ch_valid = 4'b1011;
        ng = 0; t = 0;
        while (ng < 6 && t < 100) begin
            for (int i = 0; i < NCH; i++)
                if (ch_valid[i] && ch_ready[i]) begin
                    if (ng < 6) gord[ng] = i;
                    ng++;
                end
            @(negedge clk);
            t++;
        end
        ch_valid = '0; ch_last = '0;
        chk("grant_count", ng, 6);
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("grant_order_%0d", r), gord[r], exp_ord[r]);
            expq.push_back({8'hA5, 4'(exp_ord[r]), 4'h0, 16'(r / 3)});
            expq.push_back(32'hC000_0000 | exp_ord[r]);
        end
        drain();

        // Backpressure: 20-word burst with no reads fills the 16-word buffer
        do_reset(1);
        load_round(4'b0010, 20, 0);
        repeat (40) step(0);
        chk("full_accept_cnt", bidx[1] + int'(acc[1]), 15);
        chk("full_ready_low", ch_ready[1], 1'b0);
        chk("full_not_empty", empty, 1'b0);
        step(2);
        step(0);
        step(0);
        chk("full_refill_cnt", bidx[1] + int'(acc[1]), 16);
        chk("full_ready_again_low", ch_ready[1], 1'b0);
        drain();

        // EOF only after the last buffered word is read, dropped again by new traffic
        do_reset(1);
        load_round(4'b0001, 4, 0);
        repeat (12) step(0);
        ch_done = 4'hF;
        step(0);
        ch_done = 4'h0;
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("eof_before_rd%0d", r), eof, 1'b0);
            step(2);
        end
        chk("eof_after_drain", eof, 1'b1);
        chk("empty_at_eof", empty, 1'b1);
        step(0);
        load_round(4'b1000, 1, 0);
        step(0);
        step(0);
        chk("eof_dropped_by_valid", eof, 1'b0);
        drain();
        chk("eof_restored", eof, 1'b1);

        // Close mid-burst flushes; reopen restarts sequence numbers
        do_reset(1);
        load_round(4'b0001, 10, 0);
        t = 0;
        while (bidx[0] + int'(acc[0]) < 5 && t < 50) begin step(0); t++; end
        chk("close_pre_not_empty", empty, 1'b0);
        open_i = 1'b0;
        step(0);
        chk("close_empty", empty, 1'b1);
        chk("close_ready", ch_ready, 4'h0);
        chk("close_eof", eof, 1'b0);
        step(0);
        step(0);
        chk("closed_ready_stays", ch_ready, 4'h0);
        clear_engine();
        open_i = 1'b1;
        load_round(4'b0001, 2, 0);
        drain();

        // Random rounds against the reference model
        do_reset(1);
        for (int r = 0; r < 25; r++) begin
            load_round(4'($urandom_range(1, 15)), 0, 1);
            drain();
        end
        chk("rand_no_ovf", ovf, 1'b0);

        // Asynchronous reset in the middle of a burst
        do_reset(1);
        load_round(4'b0010, 8, 0);
        t = 0;
        while (bidx[1] + int'(acc[1]) < 3 && t < 50) begin step(0); t++; end
        #2 rst_n = 1'b0;
        #1;
        chk("areset_ready", ch_ready, 4'h0);
        chk("areset_empty", empty, 1'b1);
        chk("areset_eof", eof, 1'b0);
        chk("areset_data", rdata, 32'h0);
        @(negedge clk);
        clear_engine();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("no_partial_hdr", empty, 1'b1);
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        chk("ovf_set", ovf, 1'b1);
        open_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf_sticky_on_close", ovf, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
